// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and fetch state encoding
package mips_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_t;

   // jr/jalr take their target from rs rather than the instruction word
   function automatic logic is_jump_reg(input logic [31:0] word);
      return (word[31:26] == OP_RTYPE) && ((word[5:0] == FN_JR) || (word[5:0] == FN_JALR));
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection for the retiring instruction
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        branch_cond,
   input  logic [31:0] rs_value,
   output logic [31:0] next_pc,
   output logic        misalign_hit
);

   logic [31:0] branch_off;

   assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      next_pc      = pc_plus4;
      misalign_hit = 1'b0;
      if (Jump && is_jump_reg(instr)) begin
         next_pc      = {rs_value[31:2], 2'b00};
         misalign_hit = (rs_value[1:0] != 2'b00);
      end else if (Jump) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (Branch && branch_cond) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetch front end
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        branch_cond,
   input  logic [31:0] rs_value,
   output logic        misalign,
   output logic [31:0] retired_count
);

   fetch_state_t state, state_nxt;
   logic [31:0]  next_pc;
   logic         misalign_hit;
   logic         retire;

   assign retire         = (state == ST_HOLD) && instr_ready;
   assign pc_plus4       = pc + 32'd4;
   assign opcode         = instr[31:26];
   assign funct          = instr[5:0];
   assign imem_req_addr  = pc;
   assign imem_req_valid = (state == ST_REQ);
   assign instr_valid    = (state == ST_HOLD);

   next_pc_calc u_next_pc (
      .pc_plus4     (pc_plus4),
      .instr        (instr),
      .Branch       (Branch),
      .Jump         (Jump),
      .branch_cond  (branch_cond),
      .rs_value     (rs_value),
      .next_pc      (next_pc),
      .misalign_hit (misalign_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_RESET;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET: state_nxt = ST_REQ;
         ST_REQ:   if (imem_req_ready)  state_nxt = ST_WAIT;
         ST_WAIT:  if (imem_resp_valid) state_nxt = ST_HOLD;
         ST_HOLD:  if (instr_ready)     state_nxt = ST_REQ;
         default:  state_nxt = ST_RESET;
      endcase
   end

   // Stray responses outside WAIT never touch the held instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         instr         <= 32'd0;
         misalign      <= 1'b0;
         retired_count <= 32'd0;
      end else begin
         if ((state == ST_WAIT) && imem_resp_valid) instr <= imem_resp_data;
         if (retire) begin
            pc            <= next_pc;
            retired_count <= retired_count + 32'd1;
            if (misalign_hit) misalign <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        Branch;
   logic        Jump;
   logic        branch_cond;
   logic [31:0] rs_value;
   logic        misalign;
   logic [31:0] retired_count;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .opcode          (opcode),
      .funct           (funct),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .Branch          (Branch),
      .Jump            (Jump),
      .branch_cond     (branch_cond),
      .rs_value        (rs_value),
      .misalign        (misalign),
      .retired_count   (retired_count)
   );

   typedef struct {
      string       name;
      logic [31:0] word;
      logic        br;
      logic        jmp;
      logic        cond;
      logic [31:0] rs;
      logic [31:0] exp_next;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[$];

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference next-PC from the architectural rules, using plain arithmetic
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                              input logic br, input logic jmp, input logic cond,
                                              input logic [31:0] rs);
      logic [31:0] seq;
      int          off;
      seq = cur + 32'd4;
      off = int'($signed(word[15:0]));
      if (jmp && word[31:26] == 6'd0 && (word[5:0] == 6'd8 || word[5:0] == 6'd9))
         return rs - (rs % 32'd4);
      if (jmp)
         return (seq & 32'hF000_0000) + (32'(word[25:0]) * 32'd4);
      if (br && cond)
         return seq + 32'(off * 4);
      return seq;
   endfunction

   function automatic logic model_mis(input logic [31:0] word, input logic jmp, input logic [31:0] rs);
      return jmp && word[31:26] == 6'd0 && (word[5:0] == 6'd8 || word[5:0] == 6'd9) && (rs % 32'd4 != 0);
   endfunction

   // One full fetch/hold/retire round trip against a behavioural memory
   task automatic fetch(input logic [31:0] word, input logic br, input logic jmp, input logic cond,
                        input logic [31:0] rs, input int req_delay, input int lat, input int ret_delay,
                        input bit noise, input logic [31:0] exp_pc, output int ret_cycle);
      int n;
      logic [31:0] addr;
      n = 0;
      while (imem_req_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("req_addr", imem_req_addr, exp_pc);
      addr = imem_req_addr;
      for (int i = 0; i < req_delay; i++) begin
         step();
         chk("req_addr_stable", imem_req_addr, addr);
         chk("req_valid_stable", {31'd0, imem_req_valid}, 32'd1);
      end
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      if (noise) instr_ready = 1'b1;
      for (int i = 1; i < lat; i++) begin
         chk("wait_no_instr_valid", {31'd0, instr_valid}, 32'd0);
         chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
         step();
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = word;
      step();
      imem_resp_valid = 1'b0;
      instr_ready     = 1'b0;
      chk("instr_valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, word);
      chk("pc", pc, exp_pc);
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
      chk("funct", {26'd0, funct}, {26'd0, word[5:0]});
      for (int i = 0; i < ret_delay; i++) begin
         if (noise) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~word;
         end
         step();
         imem_resp_valid = 1'b0;
         chk("hold_instr", instr, word);
         chk("hold_pc", pc, exp_pc);
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      end
      Branch      = br;
      Jump        = jmp;
      branch_cond = cond;
      rs_value    = rs;
      instr_ready = 1'b1;
      ret_cycle   = cyc;
      step();
      instr_ready = 1'b0;
      Branch      = 1'b0;
      Jump        = 1'b0;
      branch_cond = 1'b0;
      rs_value    = 32'd0;
      chk("req_after_retire", {31'd0, imem_req_valid}, 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
      chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_pc"}, pc, 32'd0);
      chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
      chk({tag, "_retired"}, retired_count, 32'd0);
   endtask

   initial begin
      int          rc;
      int          prev_rc;
      int          n;
      logic [31:0] exp_pc;
      logic [31:0] cnt0;
      logic [31:0] word;
      logic [31:0] rs;
      logic        br, jmp, cond, exp_mis;
      logic [31:0] exp_cnt;

      vecs.push_back('{"seq0",     32'h0000_0000, 0, 0, 0, 32'h0,         32'h0000_0004, 0});
      vecs.push_back('{"seq1",     32'h0000_0000, 0, 0, 0, 32'h0,         32'h0000_0008, 0});
      vecs.push_back('{"jr_100",   32'h0000_0008, 0, 1, 0, 32'h0000_0100, 32'h0000_0100, 0});
      vecs.push_back('{"beq_tk",   32'h1000_FFFF, 1, 0, 1, 32'h0,         32'h0000_0100, 0});
      vecs.push_back('{"beq_nt",   32'h1000_FFFF, 1, 0, 0, 32'h0,         32'h0000_0104, 0});
      vecs.push_back('{"jr_hi",    32'h0000_0008, 0, 1, 0, 32'h4000_0010, 32'h4000_0010, 0});
      vecs.push_back('{"j",        32'h0800_0040, 0, 1, 0, 32'h0,         32'h4000_0100, 0});
      vecs.push_back('{"jalr_mis", 32'h0000_0009, 0, 1, 0, 32'h0000_2003, 32'h0000_2000, 1});
      vecs.push_back('{"bne_tk",   32'h1400_0003, 1, 0, 1, 32'h0,         32'h0000_2010, 1});
      vecs.push_back('{"plain",    32'h0000_0000, 0, 0, 0, 32'h0,         32'h0000_2014, 1});
      vecs.push_back('{"jr_top",   32'h0000_0008, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1});
      vecs.push_back('{"wrap",     32'h0000_0000, 0, 0, 0, 32'h0,         32'h0000_0000, 1});
      vecs.push_back('{"rtype_j",  32'h0000_0020, 0, 1, 0, 32'h0000_1234, 32'h0000_0080, 1});
      vecs.push_back('{"jal_pri",  32'h0C00_0010, 1, 1, 1, 32'h0,         32'h0000_0040, 1});
      vecs.push_back('{"beq_back", 32'h1000_FFEE, 1, 0, 1, 32'h0,         32'hFFFF_FFFC, 1});

      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      instr_ready     = 1'b0;
      Branch          = 1'b0;
      Jump            = 1'b0;
      branch_cond     = 1'b0;
      rs_value        = 32'd0;
      repeat (3) step();
      check_reset_state("reset");
      chk("reset_pc_plus4", pc_plus4, 32'd4);
      rst = 1'b0;

      exp_pc  = 32'd0;
      prev_rc = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         fetch(vecs[i].word, vecs[i].br, vecs[i].jmp, vecs[i].cond, vecs[i].rs, 0, 1, 0, 0, exp_pc, rc);
         chk({vecs[i].name, "_next"}, imem_req_addr, vecs[i].exp_next);
         chk({vecs[i].name, "_mis"}, {31'd0, misalign}, {31'd0, vecs[i].exp_mis});
         chk({vecs[i].name, "_count"}, retired_count, 32'(i + 1));
         if (i > 0) chk({vecs[i].name, "_spacing"}, 32'(rc - prev_rc), 32'd3);
         prev_rc = rc;
         exp_pc  = vecs[i].exp_next;
      end

      // Back-pressure on every handshake plus ignored stray strobes
      cnt0 = retired_count;
      fetch(32'h0000_0000, 0, 0, 0, 32'h0, 5, 4, 3, 1, exp_pc, rc);
      chk("bp_next", imem_req_addr, 32'h0000_0000);
      chk("bp_count", retired_count, cnt0 + 32'd1);
      chk("bp_mis_sticky", {31'd0, misalign}, 32'd1);

      // Reset one cycle after request acceptance
      n = 0;
      while (imem_req_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("mr_req_valid", {31'd0, imem_req_valid}, 32'd1);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      step();
      check_reset_state("midrst");
      rst = 1'b0;

      // Randomised traffic against the reference model
      exp_pc  = 32'd0;
      exp_mis = 1'b0;
      exp_cnt = 32'd0;
      for (int k = 0; k < 60; k++) begin
         word = $urandom;
         case ($urandom_range(0, 5))
            0: word[31:26] = 6'h00;
            1: word[31:26] = 6'h02;
            2: word[31:26] = 6'h03;
            3: word[31:26] = 6'h04;
            4: word[31:26] = 6'h05;
            default: ;
         endcase
         if (word[31:26] == 6'h00) begin
            case ($urandom_range(0, 2))
               0: word[5:0] = 6'h08;
               1: word[5:0] = 6'h09;
               default: ;
            endcase
         end
         rs   = $urandom;
         br   = 1'($urandom_range(0, 1));
         jmp  = 1'($urandom_range(0, 1));
         cond = 1'($urandom_range(0, 1));
         fetch(word, br, jmp, cond, rs, $urandom_range(0, 2), $urandom_range(1, 3),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), exp_pc, rc);
         exp_mis = exp_mis | model_mis(word, jmp, rs);
         exp_pc  = model_next(exp_pc, word, br, jmp, cond, rs);
         exp_cnt = exp_cnt + 32'd1;
         chk("rnd_next", imem_req_addr, exp_pc);
         chk("rnd_mis", {31'd0, misalign}, {31'd0, exp_mis});
         chk("rnd_count", retired_count, exp_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
